arm_dp_issue: RTL and testbench

Issue/retire controller on the initiator side of the arm_alu interface. It accepts one decoded data-processing instruction per handshake and evaluates its ARM condition code against the architectural CPSR, which it owns. It then drives the ALU operand/select/cpsr_prev inputs, captures alu_out and cpsr_next, updates CPSR flags, and presents the result to register-file writeback through a valid/ready handshake. It sits between decode and the register file; arm_alu is instantiated beside it.

---
 rtl/arm_dp_issue.sv | 199 +++++++++++++++++++
 tb/tb_arm_dp_issue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_dp_issue.sv
// Issue/retire controller for one ARM data-processing instruction at a time.
// Owns the CPSR. Evaluates the condition code and drives the external arm_alu.
// Captures the ALU result and hands it to register-file writeback.
module arm_dp_issue #(
  parameter logic [31:0] CPSR_RESET = 32'h0000_00D3,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic [3:0]       in_opcode,
  input  logic             in_s,
  input  logic [3:0]       in_rd,
  input  logic [31:0]      in_op1,
  input  logic [31:0]      in_op2,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [3:0]       alu_op_sel,
  output logic [31:0]      alu_cpsr_prev,
  input  logic [31:0]      alu_out,
  input  logic [31:0]      alu_cpsr_next,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [3:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [31:0]      cpsr,
  input  logic             cpsr_wr_en,
  input  logic [31:0]      cpsr_wr_data,
  output logic [CNT_W-1:0] exec_count,
  output logic [CNT_W-1:0] skip_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [31:0]      cpsr_q,     cpsr_d;
  logic             wb_valid_q, wb_valid_d;
  logic [3:0]       wb_rd_q,    wb_rd_d;
  logic [31:0]      wb_data_q,  wb_data_d;
  logic [31:0]      op1_q,      op1_d;
  logic [31:0]      op2_q,      op2_d;
  logic [3:0]       opcode_q,   opcode_d;
  logic [3:0]       cond_q,     cond_d;
  logic             s_q,        s_d;
  logic [3:0]       rd_q,       rd_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

  logic cond_ok;
  logic is_compare;

  // Only the NZCV nibble of the ALU's CPSR view is ever consumed.
  logic unused_cpsr_bits;
  assign unused_cpsr_bits = ^alu_cpsr_next[27:0];

  // flags is the NZCV nibble, N in bit 3.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c && !z;
      4'b1001: cond_pass = !c || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign cond_ok    = cond_pass(cond_q, cpsr_q[31:28]);
  assign is_compare = (opcode_q[3:2] == 2'b10);

  // NOTE: every _d starts as its _q so no path through the case leaves a
  // variable unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d    = state_q;
    cpsr_d     = cpsr_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opcode_d   = opcode_q;
    cond_d     = cond_q;
    s_d        = s_q;
    rd_d       = rd_q;
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op1_d    = in_op1;
          op2_d    = in_op2;
          opcode_d = in_opcode;
          cond_d   = in_cond;
          s_d      = in_s;
          rd_d     = in_rd;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cond_ok) begin
          exec_cnt_d = exec_cnt_q + CNT_W'(1);
          if (s_q || is_compare) begin
            cpsr_d[31:28] = alu_cpsr_next[31:28];
          end
          if (is_compare) begin
            state_d = ST_IDLE;
          end else begin
            wb_data_d  = alu_out;
            wb_rd_d    = rd_q;
            wb_valid_d = 1'b1;
            state_d    = ST_WB;
          end
        end else begin
          skip_cnt_d = skip_cnt_q + CNT_W'(1);
          state_d    = ST_IDLE;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An MSR write overrides any flag update made in the same cycle.
    if (cpsr_wr_en) begin
      cpsr_d = cpsr_wr_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cpsr_q     <= CPSR_RESET;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      opcode_q   <= '0;
      cond_q     <= '0;
      s_q        <= 1'b0;
      rd_q       <= '0;
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cpsr_q     <= cpsr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      opcode_q   <= opcode_d;
      cond_q     <= cond_d;
      s_q        <= s_d;
      rd_q       <= rd_d;
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_op_sel    = opcode_q;
  assign alu_cpsr_prev = cpsr_q;
  assign cpsr          = cpsr_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign exec_count    = exec_cnt_q;
  assign skip_count    = skip_cnt_q;

endmodule

// File: tb/tb_arm_dp_issue.sv
// Directed bench for arm_dp_issue with a behavioural arm_alu beside it and a
// writeback scoreboard popped on every retired handshake.
module tb_arm_dp_issue;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_cond;
  logic [3:0]       in_opcode;
  logic             in_s;
  logic [3:0]       in_rd;
  logic [31:0]      in_op1;
  logic [31:0]      in_op2;
  logic [31:0]      alu_op1;
  logic [31:0]      alu_op2;
  logic [3:0]       alu_op_sel;
  logic [31:0]      alu_cpsr_prev;
  logic [31:0]      alu_out;
  logic [31:0]      alu_cpsr_next;
  logic             wb_valid;
  logic             wb_ready;
  logic [3:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [31:0]      cpsr;
  logic             cpsr_wr_en;
  logic [31:0]      cpsr_wr_data;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] skip_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t exp_q[$];

  always #5 clk = ~clk;

  arm_dp_issue #(.CPSR_RESET(32'h0000_00D3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_opcode(in_opcode), .in_s(in_s), .in_rd(in_rd),
    .in_op1(in_op1), .in_op2(in_op2),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op_sel(alu_op_sel),
    .alu_cpsr_prev(alu_cpsr_prev), .alu_out(alu_out), .alu_cpsr_next(alu_cpsr_next),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .cpsr(cpsr), .cpsr_wr_en(cpsr_wr_en), .cpsr_wr_data(cpsr_wr_data),
    .exec_count(exec_count), .skip_count(skip_count)
  );

  // Behavioural ALU: logical ops keep C and V, arithmetic ops compute them.
  always_comb begin
    logic [31:0] a, b, x, y, res;
    logic [32:0] sum;
    logic        ci, c, v, arith;
    a = alu_op1;
    b = alu_op2;
    c = alu_cpsr_prev[29];
    v = alu_cpsr_prev[28];
    x = a; y = b; ci = 1'b0; arith = 1'b0; res = '0;
    case (alu_op_sel)
      4'h0, 4'h8: res = a & b;
      4'h1, 4'h9: res = a ^ b;
      4'h2, 4'hA: begin x = a;  y = ~b; ci = 1'b1; arith = 1'b1; end
      4'h3:       begin x = b;  y = ~a; ci = 1'b1; arith = 1'b1; end
      4'h4, 4'hB: begin x = a;  y = b;  ci = 1'b0; arith = 1'b1; end
      4'h5:       begin x = a;  y = b;  ci = c;    arith = 1'b1; end
      4'h6:       begin x = a;  y = ~b; ci = c;    arith = 1'b1; end
      4'h7:       begin x = b;  y = ~a; ci = c;    arith = 1'b1; end
      4'hC:       res = a | b;
      4'hD:       res = b;
      4'hE:       res = a & ~b;
      default:    res = ~b;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    if (arith) begin
      res = sum[31:0];
      c   = sum[32];
      v   = (x[31] == y[31]) && (res[31] != x[31]);
    end
    alu_out       = res;
    alu_cpsr_next = {res[31], (res == 32'd0), c, v, alu_cpsr_prev[27:0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  // Returns one time unit after the accepting edge, i.e. while the DUT is in EXEC.
  task automatic issue(input logic [3:0] cond, input logic [3:0] opc, input logic s,
                       input logic [3:0] rd, input logic [31:0] op1, input logic [31:0] op2);
    wait_idle();
    in_valid  = 1'b1;
    in_cond   = cond;
    in_opcode = opc;
    in_s      = s;
    in_rd     = rd;
    in_op1    = op1;
    in_op2    = op2;
    step();
    in_valid  = 1'b0;
  endtask

  // Scoreboard: a handshake seen here retires on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_wb", {28'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("sb_wb_rd", {28'd0, wb_rd}, {28'd0, e.rd});
        chk("sb_wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_cond = '0; in_opcode = '0; in_s = 1'b0;
    in_rd = '0; in_op1 = '0; in_op2 = '0; wb_ready = 1'b1;
    cpsr_wr_en = 1'b0; cpsr_wr_data = '0;
    repeat (2) step();
    chk("rst_cpsr", cpsr, 32'h0000_00D3);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_op_sel", {28'd0, alu_op_sel}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_exec", 32'(exec_count), 32'd0);
    chk("rst_skip", 32'(skip_count), 32'd0);
    rst_n = 1'b1;

    // ADD S=1: 32+96
    exp_q.push_back('{rd: 4'd1, data: 32'h0000_0080});
    issue(4'hE, 4'h4, 1'b1, 4'd1, 32'd32, 32'd96);
    chk("add_exec_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("add_alu_op2", alu_op2, 32'd96);
    step();
    chk("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("add_wb_data", wb_data, 32'h0000_0080);
    chk("add_wb_rd", {28'd0, wb_rd}, 32'd1);
    chk("add_cpsr", cpsr, 32'h0000_00D3);
    chk("add_exec", 32'(exec_count), 32'd1);
    step();
    chk("add_retired", {31'd0, in_ready}, 32'd1);

    // SUB S=1: 32-96
    exp_q.push_back('{rd: 4'd2, data: 32'hFFFF_FFC0});
    issue(4'hE, 4'h2, 1'b1, 4'd2, 32'd32, 32'd96);
    step();
    chk("sub_wb_data", wb_data, 32'hFFFF_FFC0);
    chk("sub_cpsr", cpsr, 32'h8000_00D3);
    step();

    // CMP S=0: flags update, no writeback, idle after two edges
    issue(4'hE, 4'hA, 1'b0, 4'd3, 32'd96, 32'd96);
    chk("cmp_exec_busy", {31'd0, in_ready}, 32'd0);
    step();
    chk("cmp_idle", {31'd0, in_ready}, 32'd1);
    chk("cmp_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("cmp_cpsr", cpsr, 32'h6000_00D3);
    chk("cmp_exec", 32'(exec_count), 32'd3);

    // MSR in IDLE clears Z, then EOR EQ skips and EOR NE executes
    cpsr_wr_en = 1'b1; cpsr_wr_data = 32'h0000_00D3;
    step();
    cpsr_wr_en = 1'b0;
    chk("msr_idle_cpsr", cpsr, 32'h0000_00D3);
    issue(4'h0, 4'h1, 1'b0, 4'd4, 32'd32, 32'd96);
    step();
    chk("eq_skip_idle", {31'd0, in_ready}, 32'd1);
    chk("eq_skip_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("eq_skip_count", 32'(skip_count), 32'd1);
    chk("eq_skip_exec", 32'(exec_count), 32'd3);
    chk("eq_skip_cpsr", cpsr, 32'h0000_00D3);
    exp_q.push_back('{rd: 4'd4, data: 32'h0000_0040});
    issue(4'h1, 4'h1, 1'b0, 4'd4, 32'd32, 32'd96);
    step();
    chk("ne_wb_data", wb_data, 32'h0000_0040);
    step();

    // ORR with writeback stalled for five cycles
    wb_ready = 1'b0;
    exp_q.push_back('{rd: 4'd5, data: 32'h0000_0060});
    issue(4'hE, 4'hC, 1'b0, 4'd5, 32'h20, 32'h40);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("stall_wb_data", wb_data, 32'h0000_0060);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    wb_ready = 1'b1;
    step();
    chk("stall_retired_valid", {31'd0, wb_valid}, 32'd0);
    chk("stall_retired_ready", {31'd0, in_ready}, 32'd1);

    // MSR during EXEC of an S=1 ADD wins over the ALU flags
    exp_q.push_back('{rd: 4'd6, data: 32'h0000_0080});
    issue(4'hE, 4'h4, 1'b1, 4'd6, 32'd32, 32'd96);
    cpsr_wr_en = 1'b1; cpsr_wr_data = 32'hF000_00D3;
    step();
    cpsr_wr_en = 1'b0;
    chk("msr_exec_cpsr", cpsr, 32'hF000_00D3);
    chk("msr_exec_wb", {31'd0, wb_valid}, 32'd1);
    step();
    chk("msr_exec_count", 32'(exec_count), 32'd6);

    // Reset during a stalled writeback aborts it
    wb_ready = 1'b0;
    issue(4'hE, 4'hC, 1'b0, 4'd7, 32'd1, 32'd2);
    step();
    chk("abort_pre_wb", {31'd0, wb_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("abort_cpsr", cpsr, 32'h0000_00D3);
    chk("abort_exec", 32'(exec_count), 32'd0);
    chk("abort_skip", 32'(skip_count), 32'd0);
    chk("abort_alu_op1", alu_op1, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    wb_ready = 1'b1;

    // Seventeen never-conditions wrap the 4-bit skip counter to 1
    for (int i = 0; i < 17; i++) begin
      issue(4'hF, 4'h4, 1'b1, 4'd8, 32'd1, 32'd1);
      step();
    end
    chk("wrap_skip", 32'(skip_count), 32'd1);
    chk("wrap_exec", 32'(exec_count), 32'd0);
    chk("wrap_cpsr", cpsr, 32'h0000_00D3);
    chk("wrap_no_wb", {31'd0, wb_valid}, 32'd0);

    step();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
